// File: rtl/bit_serializer_pkg.sv
// Shared types and sizing helpers for the bit serializer.
// Imported by the top level and the PISO shift register.
package bit_serializer_pkg;

  typedef enum logic {
    ST_IDLE  = 1'b0,
    ST_SHIFT = 1'b1
  } state_t;

  localparam int DEF_WIDTH = 8;
  localparam int DEF_CNT_W = $clog2(DEF_WIDTH);

  function automatic int cnt_width(input int w);
    return (w < 2) ? 1 : $clog2(w);
  endfunction

endpackage

// File: rtl/bit_serializer_piso.sv
// Parallel-load, shift-one register with selectable bit order.
// Exposes the first bit of the load value and the bit after a shift.
module shift_reg_piso
  import bit_serializer_pkg::*;
#(
  parameter int WIDTH     = 8,
  parameter bit MSB_FIRST = 1'b1
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             load,
  input  logic             shift,
  input  logic [WIDTH-1:0] d,
  output logic             first,
  output logic             nxt
);

  logic [WIDTH-1:0] q;

  always_ff @(posedge clk) begin
    if (reset) begin
      q <= '0;
    end else if (load) begin
      q <= d;
    end else if (shift) begin
      if (MSB_FIRST) q <= {q[WIDTH-2:0], 1'b0};
      else           q <= {1'b0, q[WIDTH-1:1]};
    end
  end

  assign first = MSB_FIRST ? d[WIDTH-1] : d[0];
  assign nxt   = MSB_FIRST ? q[WIDTH-2] : q[1];

endmodule

// File: rtl/bit_serializer.sv
// Word-to-bit serializer with a one-word holding register.
// Streams gap-free at one bit per clock; idles at IDLE_BIT.
module bit_serializer
  import bit_serializer_pkg::*;
#(
  parameter int WIDTH     = 8,
  parameter bit MSB_FIRST = 1'b1,
  parameter bit IDLE_BIT  = 1'b0
) (
  input  logic             clk,
  input  logic             reset,
  input  logic [WIDTH-1:0] data_in,
  input  logic             data_valid,
  output logic             data_ready,
  output logic             dout,
  output logic             dout_valid,
  output logic             frame_start,
  output logic             busy
);

  localparam int            CW   = cnt_width(WIDTH);
  localparam logic [CW-1:0] LAST = CW'(WIDTH - 1);

  state_t           state, state_n;
  logic [CW-1:0]    cnt, cnt_n;
  logic [WIDTH-1:0] hold, load_val;
  logic             hold_full;
  logic             xfer, last;
  logic             load, shift;
  logic             hold_wr, hold_clr;
  logic             first_bit, nxt_bit;
  logic             dout_n, valid_n, fs_n;

  assign data_ready = !reset && !hold_full;
  assign xfer       = data_valid && data_ready;
  assign last       = (state == ST_SHIFT) && (cnt == LAST);
  assign busy       = (state == ST_SHIFT) || hold_full;

  always_comb begin
    state_n  = state;
    cnt_n    = cnt;
    load     = 1'b0;
    shift    = 1'b0;
    load_val = data_in;
    hold_wr  = 1'b0;
    hold_clr = 1'b0;
    unique case (state)
      ST_IDLE: begin
        if (xfer) begin
          load    = 1'b1;
          cnt_n   = '0;
          state_n = ST_SHIFT;
        end
      end
      ST_SHIFT: begin
        if (last) begin
          cnt_n = '0;
          // A held word drains ahead of any bypass load
          if (hold_full) begin
            load     = 1'b1;
            load_val = hold;
            hold_clr = 1'b1;
          end else if (xfer) begin
            load = 1'b1;
          end else begin
            state_n = ST_IDLE;
          end
        end else begin
          shift   = 1'b1;
          cnt_n   = cnt + CW'(1);
          hold_wr = xfer;
        end
      end
      default: state_n = ST_IDLE;
    endcase
  end

  always_comb begin
    dout_n  = IDLE_BIT;
    valid_n = load || shift;
    fs_n    = load;
    if (load)       dout_n = first_bit;
    else if (shift) dout_n = nxt_bit;
  end

  shift_reg_piso #(
    .WIDTH     (WIDTH),
    .MSB_FIRST (MSB_FIRST)
  ) u_piso (
    .clk   (clk),
    .reset (reset),
    .load  (load),
    .shift (shift),
    .d     (load_val),
    .first (first_bit),
    .nxt   (nxt_bit)
  );

  always_ff @(posedge clk) begin
    if (reset) begin
      state       <= ST_IDLE;
      cnt         <= '0;
      hold        <= '0;
      hold_full   <= 1'b0;
      dout        <= IDLE_BIT;
      dout_valid  <= 1'b0;
      frame_start <= 1'b0;
    end else begin
      state       <= state_n;
      cnt         <= cnt_n;
      dout        <= dout_n;
      dout_valid  <= valid_n;
      frame_start <= fs_n;
      if (hold_wr) begin
        hold      <= data_in;
        hold_full <= 1'b1;
      end else if (hold_clr) begin
        hold_full <= 1'b0;
      end
    end
  end

endmodule

// File: doc/bit_serializer.md
Name: bit_serializer

Overview:
Upstream feeder for the serial sequence-detector stage. It accepts parallel words over a valid/ready handshake and shifts them out one bit per clock on `dout`, which drives the detector's `din`. A one-word holding register lets consecutive words stream gap-free. When no word is available, `dout` sits at a fixed idle level.

Parameters:
- WIDTH, 8: bits per input word; must be at least 2.
- MSB_FIRST, 1: 1 shifts bit WIDTH-1 first; 0 shifts bit 0 first.
- IDLE_BIT, 0: value driven on `dout` when no word is being shifted.

Ports:
- clk  input  1  system clock; all state updates on the rising edge.
- reset  input  1  synchronous, active-high reset.
- data_in  input  WIDTH  parallel word to serialize.
- data_valid  input  1  `data_in` is valid this cycle.
- data_ready  output  1  block can accept a word this cycle.
- dout  output  1  serial bit; connects to the detector's `din`.
- dout_valid  output  1  `dout` carries a real data bit, not the idle level.
- frame_start  output  1  high for the cycle carrying the first bit of each word.
- busy  output  1  shift register or holding register occupied.

Behaviour:
- Clock and reset: one clock `clk`; `reset` is synchronous and active-high, sampled on the rising edge of `clk`.
- Reset values: state=IDLE, shift register cleared, holding register empty, bit counter=0.
  - Registered outputs: dout=IDLE_BIT, dout_valid=0, frame_start=0.
  - busy=0.
  - data_ready=0 while reset is high, 1 on the first cycle after reset.
- Handshake:
  - A word transfers on a clock edge where data_valid && data_ready.
  - data_ready = !reset && !hold_full. It is combinational from registered state only; there is no path from data_valid to data_ready.
  - The upstream side must hold data_in stable while data_valid=1 && data_ready=0.
- State machine (2 states):
  - IDLE: on transfer, load the word into the shift register, bit counter=0, go to SHIFT.
  - SHIFT: each cycle present the next bit, bit counter += 1. On the last-bit cycle (counter=WIDTH-1):
    - if the holding register is full, move it into the shift register, clear hold, counter=0, stay in SHIFT;
    - else if a transfer occurs this cycle, load the incoming word directly into the shift register and stay in SHIFT;
    - else go to IDLE.
  - SHIFT, not on the last bit: an accepted word goes to the holding register.
- Outputs and latency:
  - dout, dout_valid and frame_start are registered.
  - A word accepted at edge N has its first bit on dout in the cycle after edge N, i.e. latency 1.
  - Each word occupies exactly WIDTH consecutive dout_valid cycles.
  - Back-to-back words produce no idle gap.
  - frame_start=1 exactly on bit 0 of each word.
  - When no word is being shifted: dout=IDLE_BIT and dout_valid=0.
- Throughput: sustained 1 bit/clock. data_ready drops for at most WIDTH-1 cycles per word when hold is full.
- Simultaneous events:
  - Hold full at the last bit: hold drains first. data_ready is 0 that cycle, so no incoming word is lost.
  - Hold empty at the last bit with a transfer present: the bypass load applies.
- Reset mid-word: the in-flight word and the held word are discarded. The next cycle shows reset values.
- busy = (state==SHIFT) || hold_full.

Decomposition:
- Shared package: state encoding constants (ST_IDLE, ST_SHIFT), and a localparam for bit counter width = clog2(WIDTH).
- One natural sub-module, `shift_reg_piso`: parallel-load, shift-one register with MSB_FIRST selection. The FSM, holding register and handshake stay in the top level.

Test Plan:
1. WIDTH=8, MSB_FIRST=1: send 8'hE0 once.
   - dout = 1,1,1,0,0,0,0,0 on consecutive cycles starting 1 cycle after the transfer.
   - frame_start on the first bit; a downstream detector for 111000 pulses y=1 on the 6th bit.
2. Back-to-back 8'hE3 then 8'h8F with data_valid held high.
   - 16 contiguous dout_valid cycles: 11100011 10001111.
   - data_ready drops while hold is full.
   - frame_start is high on cycles 1 and 9.
3. Backpressure: present three words continuously.
   - Every word appears exactly once, in order.
   - No data_valid && data_ready transfer occurs while hold_full.
4. Reset asserted on bit 3 of 8'hAA with 8'h55 held.
   - Next cycle: dout=IDLE_BIT, dout_valid=0, busy=0, data_ready=0.
   - After reset: data_ready=1 and no bits from either discarded word are emitted.
5. MSB_FIRST=0: send 8'h07 -> dout = 1,1,1,0,0,0,0,0.
6. Idle gap: send a word, wait 5 cycles, send another.
   - dout=IDLE_BIT with dout_valid=0 during the gap.
   - The second word starts 1 cycle after its transfer.
